axis_to_wb_writer: RTL and testbench

// Streams an AXI-Stream byte source into consecutive words of a pipelined Wishbone slave (wb_sdram).

---
 rtl/axis_to_wb_writer.sv | 206 ++++++++++++++++++++
 tb/tb_axis_to_wb_writer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_wb_writer.sv
// rtl/axis_to_wb_writer.sv - AXI-Stream byte source to pipelined Wishbone word writer
//
// Purpose: packs an 8-bit AXI-Stream into little-endian Wishbone words and
// writes them to consecutive word addresses, starting at cmd_addr, for
// cmd_len words. Writes are pipelined, honour m_wb_stall and never exceed
// MAX_OUTSTANDING unacknowledged writes.
//
// Ports:
//   clk, areset                          clock, asynchronous active-high reset
//   cmd_start/cmd_addr/cmd_len           command pulse, first word address, word count
//   busy/done/short_err                  status (done is a 1-cycle pulse, short_err sticky)
//   axis_i_tready/tvalid/tlast/tdata     byte-wide stream input
//   m_wb_addr/dat_m2s/sel/we/stb/cyc     Wishbone master request side
//   m_wb_ack/m_wb_stall                  Wishbone slave response side
module axis_to_wb_writer #(
    parameter int WB_BYTES        = 2,
    parameter int ADDR_BITS       = 23,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    cmd_start,
    input  logic [ADDR_BITS-1:0]    cmd_addr,
    input  logic [15:0]             cmd_len,
    output logic                    busy,
    output logic                    done,
    output logic                    short_err,
    output logic                    axis_i_tready,
    input  logic                    axis_i_tvalid,
    input  logic                    axis_i_tlast,
    input  logic [7:0]              axis_i_tdata,
    output logic [ADDR_BITS-1:0]    m_wb_addr,
    output logic [WB_BYTES*8-1:0]   m_wb_dat_m2s,
    output logic [WB_BYTES-1:0]     m_wb_sel,
    output logic                    m_wb_we,
    output logic                    m_wb_stb,
    output logic                    m_wb_cyc,
    input  logic                    m_wb_ack,
    input  logic                    m_wb_stall
);

    localparam int IDX_W = (WB_BYTES > 1) ? $clog2(WB_BYTES) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [WB_BYTES*8-1:0]   r_dat;
    logic [WB_BYTES-1:0]     r_sel;
    logic [IDX_W-1:0]        r_byte_idx;
    logic [15:0]             r_len;
    logic [15:0]             r_issued;
    logic [OUT_W-1:0]        r_outstanding;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_short_err;
    logic                    r_tready;
    logic                    r_stb;
    logic                    r_cyc;

    logic                    w_accept;
    logic                    w_ack_eff;
    logic [OUT_W-1:0]        w_out_next;
    logic                    w_room;
    logic                    w_byte_take;
    logic                    w_word_full;
    logic                    w_last_word;

    assign w_accept    = r_stb && !m_wb_stall;
    // An ack with nothing outstanding is dropped so the counter cannot underflow.
    assign w_ack_eff   = m_wb_ack && (r_outstanding != '0);
    assign w_byte_take = r_tready && axis_i_tvalid;
    assign w_word_full = (r_byte_idx == IDX_W'(WB_BYTES - 1));
    assign w_last_word = (r_issued == (r_len - 16'd1));

    always_comb begin
        w_out_next = r_outstanding;
        if (w_accept && !w_ack_eff) begin
            w_out_next = r_outstanding + OUT_W'(1);
        end else if (!w_accept && w_ack_eff) begin
            w_out_next = r_outstanding - OUT_W'(1);
        end
    end

    // stb is registered, so the decision to raise it looks at next cycle's count.
    assign w_room = (w_out_next < OUT_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_dat         <= '0;
            r_sel         <= '0;
            r_byte_idx    <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_outstanding <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_short_err   <= 1'b0;
            r_tready      <= 1'b0;
            r_stb         <= 1'b0;
            r_cyc         <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            case (r_state)
                S_IDLE: begin
                    if (cmd_start) begin
                        r_short_err <= 1'b0;
                        r_addr      <= cmd_addr;
                        r_len       <= cmd_len;
                        r_issued    <= '0;
                        if (cmd_len == 16'd0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_FILL;
                            r_busy     <= 1'b1;
                            r_tready   <= 1'b1;
                            r_dat      <= '0;
                            r_sel      <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                end
                S_FILL: begin
                    if (w_byte_take) begin
                        for (int k = 0; k < WB_BYTES; k++) begin
                            if (r_byte_idx == IDX_W'(k)) begin
                                r_dat[8*k +: 8] <= axis_i_tdata;
                                r_sel[k]        <= 1'b1;
                            end
                        end
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                        if (w_word_full || axis_i_tlast) begin
                            r_tready <= 1'b0;
                            r_state  <= S_ISSUE;
                            if (w_room) begin
                                r_stb <= 1'b1;
                                r_cyc <= 1'b1;
                            end
                            // tlast exactly on the final byte of the final word is a clean end.
                            if (axis_i_tlast && !(w_word_full && w_last_word)) begin
                                r_short_err <= 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_stb    <= 1'b0;
                        r_addr   <= r_addr + ADDR_BITS'(1);
                        r_issued <= r_issued + 16'd1;
                        if (((r_issued + 16'd1) == r_len) || r_short_err) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state    <= S_FILL;
                            r_tready   <= 1'b1;
                            r_dat      <= '0;
                            r_sel      <= '0;
                            r_byte_idx <= '0;
                        end
                    end else if (!r_stb && w_room) begin
                        r_stb <= 1'b1;
                        r_cyc <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    // Leave as soon as the final ack lands so cyc drops right after it.
                    if (w_out_next == '0) begin
                        r_cyc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign short_err     = r_short_err;
    assign axis_i_tready = r_tready;
    assign m_wb_addr     = r_addr;
    assign m_wb_dat_m2s  = r_dat;
    assign m_wb_sel      = r_sel;
    assign m_wb_we       = r_cyc;
    assign m_wb_stb      = r_stb;
    assign m_wb_cyc      = r_cyc;

endmodule

// File: tb/tb_axis_to_wb_writer.sv
// tb/tb_axis_to_wb_writer.sv - randomized self-checking bench for axis_to_wb_writer
module tb_axis_to_wb_writer;

    localparam int WB   = 2;
    localparam int AB   = 23;
    localparam int MAXO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_start;
    logic [AB-1:0]   cmd_addr;
    logic [15:0]     cmd_len;
    logic            busy, done, short_err;
    logic            axis_i_tready, axis_i_tvalid, axis_i_tlast;
    logic [7:0]      axis_i_tdata;
    logic [AB-1:0]   m_wb_addr;
    logic [15:0]     m_wb_dat_m2s;
    logic [1:0]      m_wb_sel;
    logic            m_wb_we, m_wb_stb, m_wb_cyc, m_wb_ack, m_wb_stall;

    axis_to_wb_writer #(.WB_BYTES(WB), .ADDR_BITS(AB), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .areset(rst),
        .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done), .short_err(short_err),
        .axis_i_tready(axis_i_tready), .axis_i_tvalid(axis_i_tvalid),
        .axis_i_tlast(axis_i_tlast), .axis_i_tdata(axis_i_tdata),
        .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_sel(m_wb_sel),
        .m_wb_we(m_wb_we), .m_wb_stb(m_wb_stb), .m_wb_cyc(m_wb_cyc),
        .m_wb_ack(m_wb_ack), .m_wb_stall(m_wb_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // stimulus and capture state
    logic [7:0]    stim[$];
    logic [8:0]    src_q[$];
    logic [AB-1:0] cap_addr[$];
    logic [15:0]   cap_dat[$];
    logic [1:0]    cap_sel[$];
    int consumed, pend, acks, dones, done_acks, stb_cycles, viol, cyc_rises;
    int forced_stall, stall_pct, ack_pct;
    bit hold_acks;

    // reference results
    logic [AB-1:0] exp_addr[$];
    logic [15:0]   exp_dat[$];
    logic [1:0]    exp_sel[$];
    bit            exp_short;
    int            exp_consumed;

    // stream source: offers queued bytes with random gaps
    initial begin
        axis_i_tvalid = 1'b0;
        axis_i_tlast  = 1'b0;
        axis_i_tdata  = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && src_q.size() > 0 && $urandom_range(99) < 80) begin
                axis_i_tvalid = 1'b1;
                axis_i_tdata  = src_q[0][7:0];
                axis_i_tlast  = src_q[0][8];
                if (axis_i_tready) begin
                    void'(src_q.pop_front());
                    consumed++;
                end
            end else begin
                axis_i_tvalid = 1'b0;
                axis_i_tlast  = 1'b0;
            end
        end
    end

    // Wishbone slave plus protocol watcher
    logic          prev_hold, prev_cyc;
    logic [AB-1:0] p_addr;
    logic [15:0]   p_dat;
    logic [1:0]    p_sel;
    initial begin
        m_wb_ack = 1'b0; m_wb_stall = 1'b0; prev_hold = 1'b0; prev_cyc = 1'b0;
        p_addr = '0; p_dat = '0; p_sel = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_wb_ack = 1'b0; m_wb_stall = 1'b0; prev_hold = 1'b0; prev_cyc = 1'b0;
            end else begin
                if (m_wb_stb && pend >= MAXO) viol++;
                if (m_wb_stb && !m_wb_cyc) viol++;
                if (m_wb_we !== m_wb_cyc) viol++;
                if (m_wb_cyc && !prev_cyc) begin
                    cyc_rises++;
                    if (!m_wb_stb) viol++;
                end
                if (!m_wb_cyc && prev_cyc && pend != 0) viol++;
                if (axis_i_tready && !busy) viol++;
                if (prev_hold && (!m_wb_stb || m_wb_addr != p_addr ||
                                  m_wb_dat_m2s != p_dat || m_wb_sel != p_sel)) viol++;
                if (m_wb_stb) stb_cycles++;
                if (done) begin
                    dones++;
                    done_acks = acks;
                end
                prev_cyc = m_wb_cyc;
                if (pend > 0 && !hold_acks && $urandom_range(99) < ack_pct) begin
                    m_wb_ack = 1'b1; pend--; acks++;
                end else begin
                    m_wb_ack = 1'b0;
                end
                if (m_wb_stb && forced_stall > 0) begin
                    m_wb_stall = 1'b1; forced_stall--;
                end else begin
                    m_wb_stall = ($urandom_range(99) < stall_pct);
                end
                if (m_wb_stb && !m_wb_stall) begin
                    cap_addr.push_back(m_wb_addr);
                    cap_dat.push_back(m_wb_dat_m2s);
                    cap_sel.push_back(m_wb_sel);
                    pend++;
                end
                prev_hold = m_wb_stb && m_wb_stall;
                p_addr = m_wb_addr; p_dat = m_wb_dat_m2s; p_sel = m_wb_sel;
            end
        end
    end

    task automatic tb_clear();
        src_q.delete(); cap_addr.delete(); cap_dat.delete(); cap_sel.delete(); stim.delete();
        consumed = 0; pend = 0; acks = 0; dones = 0; done_acks = 0; stb_cycles = 0;
        viol = 0; cyc_rises = 0; forced_stall = 0; hold_acks = 0;
    endtask

    // Word-level expectation: walk the byte list word by word, stop at tlast.
    task automatic model(input logic [AB-1:0] addr, input int len, input int tlast_at);
        int pos;
        pos = 0;
        exp_short = 0;
        exp_addr.delete(); exp_dat.delete(); exp_sel.delete();
        for (int w = 0; w < len; w++) begin
            logic [15:0] d;
            logic [1:0]  s;
            bit last, full;
            d = '0; s = '0; last = 0; full = 0;
            for (int k = 0; k < WB; k++) begin
                d[8*k +: 8] = stim[pos];
                s[k] = 1'b1;
                last = (pos == tlast_at);
                full = (k == WB - 1);
                pos++;
                if (last) break;
            end
            exp_addr.push_back(addr + AB'(w));
            exp_dat.push_back(d);
            exp_sel.push_back(s);
            if (last) begin
                exp_short = !(full && w == len - 1);
                break;
            end
        end
        exp_consumed = pos;
    endtask

    task automatic start_cmd(input logic [AB-1:0] addr, input int len, input int tlast_at);
        for (int i = 0; i < stim.size(); i++) src_q.push_back({(i == tlast_at), stim[i]});
        model(addr, len, tlast_at);
        @(negedge clk);
        cmd_start = 1'b1; cmd_addr = addr; cmd_len = 16'(len);
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        int t;
        t = 0;
        while (dones == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({tag, ".no_timeout"}, t < 3000, 1);
        repeat (5) @(negedge clk);
        check({tag, ".done_count"}, dones, 1);
        check({tag, ".nwrites"}, cap_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), cap_addr[i], exp_addr[i]);
            check($sformatf("%s.dat%0d", tag, i), cap_dat[i], exp_dat[i]);
            check($sformatf("%s.sel%0d", tag, i), cap_sel[i], exp_sel[i]);
        end
        check({tag, ".short_err"}, short_err, exp_short);
        check({tag, ".consumed"}, consumed, exp_consumed);
        check({tag, ".protocol"}, viol, 0);
        check({tag, ".acks_at_done"}, done_acks, exp_addr.size());
        check({tag, ".cyc_rises"}, cyc_rises, (exp_addr.size() > 0) ? 1 : 0);
        check({tag, ".idle_after"}, {busy, m_wb_cyc, m_wb_stb}, 3'b000);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_addr = '0; cmd_len = '0;
        stall_pct = 0; ack_pct = 100;
        tb_clear();
        repeat (3) @(negedge clk);
        check("reset.outputs", {busy, done, short_err, axis_i_tready, m_wb_stb, m_wb_cyc,
                                m_wb_we, m_wb_addr, m_wb_dat_m2s, m_wb_sel}, '0);
        rst = 1'b0;

        // two words, prompt acks
        tb_clear();
        stim = '{8'hAD, 8'hDE, 8'hEF, 8'hBE};
        start_cmd(23'h000100, 2, -1);
        finish_cmd("basic");
        check("basic.w0", (cap_dat.size() > 0) ? cap_dat[0] : 16'hxxxx, 16'hDEAD);
        check("basic.w1", (cap_dat.size() > 1) ? cap_dat[1] : 16'hxxxx, 16'hBEEF);
        check("basic.a1", (cap_addr.size() > 1) ? cap_addr[1] : 'x, 23'h000101);

        // first write stalled for 5 cycles
        tb_clear();
        stim = '{8'hAD, 8'hDE, 8'hEF, 8'hBE};
        forced_stall = 5;
        start_cmd(23'h000100, 2, -1);
        finish_cmd("stall5");
        check("stall5.stb_cycles", stb_cycles, 7);

        // acks withheld: only MAX_OUTSTANDING writes may go out
        tb_clear();
        for (int i = 0; i < 16; i++) stim.push_back(8'($urandom));
        hold_acks = 1;
        start_cmd(23'h001000, 8, -1);
        repeat (60) @(negedge clk);
        check("hold.accepted", cap_addr.size(), MAXO);
        check("hold.stb_low", m_wb_stb, 1'b0);
        check("hold.cyc_high", m_wb_cyc, 1'b1);
        check("hold.no_done", dones, 0);
        hold_acks = 0;
        finish_cmd("hold");

        // early tlast on the 5th byte of a 3-word command
        tb_clear();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h99, 8'h98};
        start_cmd(23'h002000, 3, 4);
        finish_cmd("short");
        check("short.dat2", (cap_dat.size() > 2) ? cap_dat[2] : 16'hxxxx, 16'h0011);
        check("short.sel2", (cap_sel.size() > 2) ? cap_sel[2] : 2'bxx, 2'b01);
        check("short.flag", short_err, 1'b1);

        // address wrap
        tb_clear();
        stim = '{8'h10, 8'h20, 8'h30, 8'h40};
        start_cmd(23'h7FFFFF, 2, -1);
        finish_cmd("wrap");
        check("wrap.a0", (cap_addr.size() > 0) ? cap_addr[0] : 'x, 23'h7FFFFF);
        check("wrap.a1", (cap_addr.size() > 1) ? cap_addr[1] : 'x, 23'h000000);

        // randomized commands
        for (int it = 0; it < 10; it++) begin
            logic [AB-1:0] a;
            int len, nb, tl;
            tb_clear();
            a = AB'($urandom);
            if ($urandom_range(3) == 0) a = 23'h7FFFFF - AB'($urandom_range(5));
            len = $urandom_range(1, 10);
            nb  = len * WB + $urandom_range(0, 3);
            for (int i = 0; i < nb; i++) stim.push_back(8'($urandom));
            tl = ($urandom_range(9) < 3) ? $urandom_range(0, len * WB - 2) : -1;
            stall_pct = $urandom_range(0, 40);
            ack_pct   = $urandom_range(30, 100);
            start_cmd(a, len, tl);
            finish_cmd($sformatf("rnd%0d", it));
        end
        stall_pct = 0; ack_pct = 100;

        // reset while a write is being stalled
        tb_clear();
        stim = '{8'h55, 8'h66, 8'h77, 8'h88};
        forced_stall = 1000;
        start_cmd(23'h000200, 2, -1);
        begin
            int t;
            t = 0;
            while (!m_wb_stb && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("rst_mid.stb_seen", m_wb_stb, 1'b1);
        end
        #2 rst = 1'b1;
        #1 check("rst_mid.async", {m_wb_stb, m_wb_cyc, busy, axis_i_tready}, 4'b0000);
        repeat (2) @(negedge clk);
        tb_clear();
        rst = 1'b0;

        // zero-length command: done with no bus activity
        start_cmd(23'h000300, 0, -1);
        check("len0.done_next", done, 1'b1);
        finish_cmd("len0");
        check("len0.no_stb", stb_cycles, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
